// File: rtl/arb_pkg.sv
// Shared types and limits for the round-robin grant arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_COOL  = 2'd2
    } arb_state_t;

    localparam int ARB_MAX_N = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          valid,
    output logic [PW-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [PW-1:0]  off;
    logic [PW:0]    sum;

    always_comb begin
        dbl   = {req, req};
        rot   = dbl[ptr +: N];
        valid = |req;
        off   = '0;
        // Descending scan so the lowest set bit of the rotated vector wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = PW'(i);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
        idx = sum[PW-1:0];
    end

endmodule

// File: rtl/rr_grant_fsm.sv
// Round-robin single-owner arbiter with hold-time limit and one-cycle turnaround.
// state     | meaning
// ARB_IDLE  | no owner, arbitrate on any request
// ARB_GRANT | one requester owns the resource, hold timer running
// ARB_COOL  | turnaround cycle between owners, grant low
module rr_grant_fsm
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    output logic                 expired
);

    localparam int PW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);

    arb_state_t    state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          expired_q, expired_d;

    logic          pick_valid;
    logic [PW-1:0] pick_idx;
    logic [PW-1:0] ptr_after_owner;

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign ptr_after_owner = (owner_q == PW'(N - 1)) ? '0 : owner_q + PW'(1);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        expired_d = expired_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    grant_d = N'(1) << pick_idx;
                    owner_d = pick_idx;
                    hold_d  = HW'(1);
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                // Withdrawal is checked first so it wins over a simultaneous timeout.
                if (!req[owner_q]) begin
                    grant_d = '0;
                    owner_d = '0;
                    ptr_d   = ptr_after_owner;
                    state_d = ARB_COOL;
                end else if (hold_q == HW'(MAX_HOLD)) begin
                    grant_d   = '0;
                    owner_d   = '0;
                    ptr_d     = ptr_after_owner;
                    expired_d = 1'b1;
                    state_d   = ARB_COOL;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            ARB_COOL: begin
                grant_d   = '0;
                owner_d   = '0;
                hold_d    = '0;
                expired_d = 1'b0;
                state_d   = ARB_IDLE;
            end
            default: begin
                grant_d   = '0;
                owner_d   = '0;
                hold_d    = '0;
                expired_d = 1'b0;
                state_d   = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            expired_q <= expired_d;
        end
    end

    assign grant   = grant_q;
    assign owner   = owner_q;
    assign busy    = (state_q != ARB_IDLE);
    assign expired = expired_q;

endmodule

// File: tb/tb_rr_grant_fsm.sv
// Directed vector table, hand sequences and a reference model for rr_grant_fsm.
module tb_rr_grant_fsm;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       areset;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic       expired;

    int total = 0;
    int bad   = 0;

    int         m_state, m_ptr, m_owner, m_hold;
    logic [3:0] m_grant;
    logic       m_exp;

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] owner;
        logic       busy;
        logic       expired;
    } vec_t;

    vec_t tbl [12];

    rr_grant_fsm #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .areset  (areset),
        .req     (req),
        .grant   (grant),
        .owner   (owner),
        .busy    (busy),
        .expired (expired)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dut_vec();
        return {grant, owner, busy, expired};
    endfunction

    function automatic logic [7:0] model_vec();
        return {m_grant, 2'(m_owner), (m_state != 0), m_exp};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_ptr = 0; m_owner = 0; m_hold = 0; m_grant = '0; m_exp = 1'b0;
    endtask

    task automatic model_clock(input logic [3:0] r);
        int w;
        w = -1;
        case (m_state)
            0: if (r != 4'b0) begin
                for (int k = 0; k < N; k++)
                    if (w < 0 && r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                m_grant = 4'b0001 << w;
                m_owner = w;
                m_hold  = 1;
                m_state = 1;
            end
            1: begin
                if (!r[m_owner]) begin
                    m_grant = '0; m_ptr = (m_owner + 1) % N; m_owner = 0; m_state = 2;
                end else if (m_hold == MAX_HOLD) begin
                    m_grant = '0; m_ptr = (m_owner + 1) % N; m_owner = 0; m_exp = 1'b1; m_state = 2;
                end else begin
                    m_hold++;
                end
            end
            default: begin
                m_grant = '0; m_owner = 0; m_hold = 0; m_exp = 1'b0; m_state = 0;
            end
        endcase
    endtask

    // Called at posedge+1: drive, check async reset mid-cycle, clock, check vs model.
    task automatic step(input logic [3:0] r, input logic rst);
        req    = r;
        areset = rst;
        #1;
        if (rst) begin
            model_reset();
            check("async_rst", dut_vec(), 8'h00);
        end
        @(posedge clk);
        if (rst) model_reset();
        else     model_clock(r);
        #1;
        check("model", dut_vec(), model_vec());
    endtask

    initial begin
        //           req      grant    own    busy  exp
        tbl[0]  = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[1]  = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[2]  = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[3]  = '{4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0};
        tbl[4]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[5]  = '{4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[6]  = '{4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[7]  = '{4'b1000, 4'b0000, 2'd0, 1'b1, 1'b0};
        tbl[8]  = '{4'b1001, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[9]  = '{4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[10] = '{4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0};
        tbl[11] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

        areset = 1'b1;
        req    = '0;
        model_reset();
        #1;
        check("reset_state", dut_vec(), 8'h00);
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].req, 1'b0);
            check($sformatf("vec%0d", i), dut_vec(),
                  {tbl[i].grant, tbl[i].owner, tbl[i].busy, tbl[i].expired});
        end

        // Timeout: eight grant cycles, expired pulse, two-cycle gap, regrant.
        step(4'b0000, 1'b1);
        for (int c = 0; c < MAX_HOLD; c++) begin
            step(4'b0100, 1'b0);
            check($sformatf("tmo_hold%0d", c), {grant, owner, expired}, {4'b0100, 2'd2, 1'b0});
        end
        step(4'b0100, 1'b0);
        check("tmo_expire", {grant, busy, expired}, {4'b0000, 1'b1, 1'b1});
        step(4'b0100, 1'b0);
        check("tmo_idle", {grant, busy, expired}, {4'b0000, 1'b0, 1'b0});
        step(4'b0100, 1'b0);
        check("tmo_regrant", {grant, owner}, {4'b0100, 2'd2});

        // Rotation with all requesters active.
        step(4'b0000, 1'b1);
        for (int o = 0; o < 5; o++) begin
            for (int c = 0; c < MAX_HOLD; c++) begin
                step(4'b1111, 1'b0);
                check($sformatf("rot%0d_c%0d", o, c), {grant, owner},
                      {4'b0001 << (o % 4), 2'(o % 4)});
            end
            step(4'b1111, 1'b0);
            check($sformatf("rot%0d_gap0", o), {grant, expired}, {4'b0000, 1'b1});
            step(4'b1111, 1'b0);
            check($sformatf("rot%0d_gap1", o), {grant, busy}, {4'b0000, 1'b0});
        end

        // Wrap: after owner 2 the pointer is 3, req=0011 picks 0 then 1.
        step(4'b0000, 1'b1);
        step(4'b0100, 1'b0);
        check("wrap_own2", owner, 2'd2);
        step(4'b0000, 1'b0);
        step(4'b0011, 1'b0);
        check("wrap_idle", {grant, busy}, {4'b0000, 1'b0});
        step(4'b0011, 1'b0);
        check("wrap_own0", {grant, owner}, {4'b0001, 2'd0});
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        check("wrap_own1", {grant, owner}, {4'b0010, 2'd1});

        // Withdrawal on the edge where the hold limit is reached.
        step(4'b0000, 1'b1);
        for (int c = 0; c < MAX_HOLD; c++) step(4'b0001, 1'b0);
        step(4'b0000, 1'b0);
        check("drop_at_max", {grant, busy, expired}, {4'b0000, 1'b1, 1'b0});
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b0);
        check("drop_ptr_adv", {grant, owner}, {4'b0010, 2'd1});

        // Async reset while owner 1 holds; pointer must return to 0.
        step(4'b0000, 1'b1);
        step(4'b0001, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0010, 1'b0);
        check("pre_rst_own1", {grant, owner}, {4'b0010, 2'd1});
        step(4'b0010, 1'b1);
        step(4'b0011, 1'b0);
        check("post_rst_ptr0", {grant, owner}, {4'b0001, 2'd0});

        for (int i = 0; i < 200; i++)
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 19) == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
